// File: rtl/riscv_mem_mmio.sv
// riscv_mem_mmio: word RAM plus GPIO, optional free-running TIMER (RISCV_MEM_TIMER_EN) and a TX byte FIFO with sticky overflow.
module riscv_mem_mmio #(
  parameter int RAM_WORDS  = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  gpio_out,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [31:0] mem_q [RAM_WORDS];
  logic [7:0] buf_q [FIFO_DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [PW:0] cnt_q, cnt_d;
  logic [7:0] gpio_q, gpio_d;
  logic ovf_q, ovf_d;
  logic ram_sel, gpio_sel, tim_sel, tx_sel, st_sel;
  logic full, empty, pop, push, push_ok;
  logic [31:0] status, tim_rd;
  logic unused_bits;
  assign unused_bits = ^Adr[1:0];
  assign ram_sel  = Adr[31:AW+2] == '0;
  assign gpio_sel = Adr[31:2] == 30'h400;
  assign tim_sel  = Adr[31:2] == 30'h401;
  assign tx_sel   = Adr[31:2] == 30'h402;
  assign st_sel   = Adr[31:2] == 30'h403;
  assign full     = cnt_q == (PW+1)'(FIFO_DEPTH);
  assign empty    = cnt_q == '0;
  assign tx_valid = !empty;
  assign tx_data  = tx_valid ? buf_q[rd_q] : '0;
  assign gpio_out = gpio_q;
  assign pop      = tx_valid && tx_ready;
  assign push     = MemWrite && tx_sel;
  // a full FIFO still takes a byte when the head leaves on the same edge
  assign push_ok  = push && (!full || pop);
  assign status   = 32'({ovf_q, 4'(cnt_q), 2'b00, empty, full});
`ifdef RISCV_MEM_TIMER_EN
  logic [31:0] tim_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) tim_q <= '0;
    else tim_q <= tim_q + 32'd1;
  assign tim_rd = tim_q;
`else
  assign tim_rd = '0;
`endif
  always_comb begin
    gpio_d = (MemWrite && gpio_sel) ? WriteData[7:0] : gpio_q;
    wr_d   = push_ok ? wr_q + 1'b1 : wr_q;
    rd_d   = pop ? rd_q + 1'b1 : rd_q;
    cnt_d  = cnt_q + (PW+1)'(push_ok) - (PW+1)'(pop);
    ovf_d  = (ovf_q && !(MemWrite && st_sel)) || (push && !push_ok);
  end
  always_comb
    ReadData = ram_sel  ? mem_q[Adr[AW+1:2]] :
               gpio_sel ? {24'b0, gpio_q} :
               tim_sel  ? tim_rd :
               st_sel   ? status : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      gpio_q <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      gpio_q <= gpio_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  // storage arrays are left out of reset; RAM must survive it
  always_ff @(posedge clk) begin
    if (MemWrite && ram_sel) mem_q[Adr[AW+1:2]] <= WriteData;
    if (push_ok) buf_q[wr_q] <= WriteData[7:0];
  end
endmodule
